// File: rtl/ota_pkg.sv
// Shared definitions for the OTA duty meter slice.
// Contents: FSM state enum, default sizing constants, edge counter width,
//           and the duty shift helper used to scale the high count.
package ota_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam int unsigned WIN_LOG2_DEF    = 8;
    localparam int unsigned OUT_W_DEF       = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned EDGE_W          = 8;

    // Right shift that maps a window's high count onto the duty output range.
    localparam int unsigned DUTY_SHIFT_DEF = WIN_LOG2_DEF - OUT_W_DEF;

    function automatic int unsigned duty_shift(input int unsigned win_log2,
                                               input int unsigned out_w);
        return win_log2 - out_w;
    endfunction

endpackage

// File: rtl/ota_duty_meter_if.sv
// Result readout bus of the duty meter.
// master (meter): drives duty, edge_cnt, duty_valid, overrun; samples duty_ack.
// slave (consumer): the reverse.
interface ota_duty_meter_if
    import ota_pkg::*;
#(
    parameter int unsigned OUT_W = OUT_W_DEF
) ();

    logic [OUT_W-1:0]  duty;
    logic [EDGE_W-1:0] edge_cnt;
    logic              duty_valid;
    logic              duty_ack;
    logic              overrun;

    modport master (
        output duty,
        output edge_cnt,
        output duty_valid,
        output overrun,
        input  duty_ack
    );

    modport slave (
        input  duty,
        input  edge_cnt,
        input  duty_valid,
        input  overrun,
        output duty_ack
    );

endinterface

// File: rtl/ota_sync.sv
// Multi-stage reset-to-0 synchroniser for asynchronous single-bit inputs.
// Ports: clk, rst (async active-high), d (async input), q (d delayed STAGES clocks).
module ota_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift chain; only chain[0] may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ota_duty_meter.sv
// Duty-cycle and rising-edge meter for the OTA comparator output.
// Measures fixed windows of 2^WIN_LOG2 clocks, back to back while en is high,
// and hands each window's result to the consumer with a valid/ack handshake.
// Ports: clk, rst (async active-high), en (measurement enable), ota_in (async
//        OTA Out net), busy (FSM in MEASURE), res (result bus, master side).
module ota_duty_meter
    import ota_pkg::*;
#(
    parameter int unsigned WIN_LOG2    = WIN_LOG2_DEF,
    parameter int unsigned OUT_W       = OUT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               ota_in,
    output logic               busy,
    ota_duty_meter_if.master   res
);

    localparam int unsigned HC_W     = WIN_LOG2 + 1;
    localparam int unsigned SHIFT    = duty_shift(WIN_LOG2, OUT_W);
    localparam int unsigned DUTY_MAX = (32'd1 << OUT_W) - 32'd1;

    state_e              state;
    logic                s;
    logic                prev;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [HC_W-1:0]     high_cnt;
    logic [EDGE_W-1:0]   edge_acc;

    logic [HC_W-1:0]     high_nxt_c;
    logic [HC_W-1:0]     high_shift_c;
    logic [EDGE_W-1:0]   edge_nxt_c;
    logic [OUT_W-1:0]    duty_sat_c;
    logic                last_c;
    logic                new_res_c;

    ota_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ota_in),
        .q   (s)
    );

    // Counter updates including the current sample, so the terminal cycle's
    // sample lands in the registered result.
    always_comb begin
        high_nxt_c   = high_cnt + HC_W'(s);
        edge_nxt_c   = edge_acc;
        if (s && !prev && (edge_acc != '1)) begin
            edge_nxt_c = edge_acc + EDGE_W'(1);
        end
        high_shift_c = high_nxt_c >> SHIFT;
        // A full-high window counts 2^WIN_LOG2, one past full scale.
        if (high_shift_c > HC_W'(DUTY_MAX)) begin
            duty_sat_c = '1;
        end else begin
            duty_sat_c = OUT_W'(high_shift_c);
        end
        last_c    = &win_cnt;
        new_res_c = (state == MEASURE) && en && last_c;
    end

    // FSM, window counters and result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            prev           <= 1'b0;
            win_cnt        <= '0;
            high_cnt       <= '0;
            edge_acc       <= '0;
            res.duty       <= '0;
            res.edge_cnt   <= '0;
            res.duty_valid <= 1'b0;
            res.overrun    <= 1'b0;
        end else begin
            prev <= s;

            if (state == IDLE) begin
                if (en) begin
                    state    <= MEASURE;
                    win_cnt  <= '0;
                    high_cnt <= '0;
                    edge_acc <= '0;
                end
            end else if (!en) begin
                // Partial window is dropped; counters are cleared on next entry.
                state <= IDLE;
            end else begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (last_c) begin
                    high_cnt <= '0;
                    edge_acc <= '0;
                end else begin
                    high_cnt <= high_nxt_c;
                    edge_acc <= edge_nxt_c;
                end
            end

            if (new_res_c) begin
                res.duty       <= duty_sat_c;
                res.edge_cnt   <= edge_nxt_c;
                res.duty_valid <= 1'b1;
            end else if (res.duty_ack) begin
                res.duty_valid <= 1'b0;
            end

            // Overwrite of an unread result is sticky until the consumer acks.
            if (new_res_c && res.duty_valid && !res.duty_ack) begin
                res.overrun <= 1'b1;
            end else if (res.duty_ack) begin
                res.overrun <= 1'b0;
            end
        end
    end

    assign busy = (state == MEASURE);

endmodule

// File: tb/tb_ota_duty_meter.sv
// Scoreboard bench for ota_duty_meter: a window-level reference model pushes
// expected results, a negedge monitor pops and compares them.
module tb_ota_duty_meter;
    import ota_pkg::*;

    localparam int unsigned WL   = 8;
    localparam int unsigned OW   = 8;
    localparam int unsigned SS   = 2;
    localparam int          WIN  = 1 << WL;
    localparam int          SH   = WL - OW;
    localparam int          DMAX = (1 << OW) - 1;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b0;
    logic ota_in = 1'b0;
    logic busy;

    ota_duty_meter_if #(.OUT_W(OW)) bus ();

    ota_duty_meter #(
        .WIN_LOG2    (WL),
        .OUT_W       (OW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ota_in (ota_in),
        .busy   (busy),
        .res    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int edges;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t     = 0;

    // Reference model state.
    bit   m_busy  = 0;
    bit   m_valid = 0;
    bit   m_ovr   = 0;
    bit   last_s  = 0;
    bit   first_prev = 0;
    bit   hist[$];
    bit   win[$];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Window-level model: collects the synchronised samples of each window and
    // scores them once the window is complete.
    initial begin
        bit   s;
        bit   newr;
        bit   ack;
        int   ones;
        int   ed;
        int   d;
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy  = 0;
                m_valid = 0;
                m_ovr   = 0;
                last_s  = 0;
                hist    = {};
                win     = {};
                exp_q   = {};
            end else begin
                cyc++;
                s    = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
                newr = 0;
                ack  = bus.duty_ack;
                if (!m_busy) begin
                    if (en) begin
                        m_busy = 1;
                        win    = {};
                    end
                end else if (!en) begin
                    m_busy = 0;
                    win    = {};
                end else begin
                    if (win.size() == 0) first_prev = last_s;
                    win.push_back(s);
                    if (win.size() == WIN) begin
                        ones = 0;
                        ed   = 0;
                        for (int i = 0; i < WIN; i++) begin
                            ones += int'(win[i]);
                            if (win[i] && !((i == 0) ? first_prev : win[i-1])) ed++;
                        end
                        d = ones >> SH;
                        if (d > DMAX) d = DMAX;
                        if (ed > 255) ed = 255;
                        e.duty  = d;
                        e.edges = ed;
                        e.due   = cyc;
                        exp_q.push_back(e);
                        newr = 1;
                        win  = {};
                    end
                end
                if (newr && m_valid && !ack) m_ovr = 1;
                else if (ack) m_ovr = 0;
                if (newr) m_valid = 1;
                else if (ack) m_valid = 0;
                last_s = s;
                hist.push_back(ota_in);
                if (hist.size() > 8) void'(hist.pop_front());
            end
        end
    end

    // Monitor: handshake flags every cycle, payload when a result is due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("busy", int'(busy), int'(m_busy));
                chk("duty_valid", int'(bus.duty_valid), int'(m_valid));
                chk("overrun", int'(bus.overrun), int'(m_ovr));
                while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    chk("duty", int'(bus.duty), e.duty);
                    chk("edge_cnt", int'(bus.edge_cnt), e.edges);
                end
            end
        end
    end

    function automatic bit pat(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4) < 2;
            2:       return 1'b0;
            3:       return (k % 4) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // ackm: 0 = ack whenever valid, 1 = never ack, 2 = random ack.
    task automatic run(input int n, input int mode, input int ackm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ota_in = pat(mode, t);
            t++;
            case (ackm)
                0:       bus.duty_ack = bus.duty_valid;
                1:       bus.duty_ack = 1'b0;
                default: bus.duty_ack = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        en           = 1'b0;
        bus.duty_ack = 1'b0;
        run(n, 2, 0);
    endtask

    task automatic seek_pos(input int pos, input int mode, input int ackm);
        for (int i = 0; i < 2 * WIN && win.size() != pos; i++) run(1, mode, ackm);
        chk("window_position_reached", win.size(), pos);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"}, int'(bus.duty), 0);
        chk({tag, "_edge_cnt"}, int'(bus.edge_cnt), 0);
        chk({tag, "_duty_valid"}, int'(bus.duty_valid), 0);
        chk({tag, "_overrun"}, int'(bus.overrun), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        bus.duty_ack = 1'b0;
        ota_in       = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");

        // Constant high from reset, two acked windows.
        rst = 1'b0;
        en  = 1'b1;
        run(2 * WIN + 4, 0, 0);

        // 2-high/2-low square wave.
        idle(4);
        en = 1'b1;
        run(3 * WIN + 4, 1, 0);

        // Constant low, then drop en at sample 100 of the following window.
        idle(4);
        en = 1'b1;
        run(WIN + 4, 2, 0);
        seek_pos(100, 2, 0);
        en = 1'b0;
        @(negedge clk);
        chk("busy_after_en_drop", int'(busy), 0);
        run(6, 2, 0);

        // 1-high/3-low, two windows unread, then a single ack.
        idle(4);
        en = 1'b1;
        run(2 * WIN + 5, 3, 1);
        chk("overrun_after_two_unread", int'(bus.overrun), 1);
        @(negedge clk);
        bus.duty_ack = 1'b1;
        @(negedge clk);
        bus.duty_ack = 1'b0;
        chk("valid_after_ack", int'(bus.duty_valid), 0);
        chk("overrun_after_ack", int'(bus.overrun), 0);
        run(4, 3, 1);

        // Ack landing on the terminal cycle of a window with a result pending.
        idle(4);
        en = 1'b1;
        run(WIN + 10, 4, 1);
        seek_pos(WIN - 1, 4, 1);
        bus.duty_ack = 1'b1;
        @(negedge clk);
        bus.duty_ack = 1'b0;
        chk("valid_after_terminal_ack", int'(bus.duty_valid), 1);
        chk("overrun_after_terminal_ack", int'(bus.overrun), 0);
        run(8, 4, 1);

        // Reset mid-window with toggling input.
        idle(4);
        en = 1'b1;
        run(WIN + 20, 4, 1);
        seek_pos(150, 4, 1);
        #2 rst = 1'b1;
        #1 chk_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        run(2 * WIN + 5, 4, 0);

        // Random soak: random input, random ack, occasional enable drops.
        for (int i = 0; i < 6 * WIN; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 299) != 0) ? 1'b1 : (i % 2 == 0);
            run(1, ($urandom_range(0, 3) == 0) ? 4 : 1 + int'($urandom_range(0, 2)), 2);
        end

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
